// File: rtl/sd_level_pkg.sv
// Shared definitions for the sigma-delta level/event detector:
// default parameter values and the detector state encoding.
package sd_level_pkg;

   localparam int unsigned SD_WIDTH_DEF = 16;
   localparam int unsigned SD_QUAL_DEF  = 4;
   localparam int unsigned SD_HOLD_DEF  = 8;
   localparam int unsigned SD_LEN_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMING = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_HOLD   = 2'd3
   } sd_state_e;

endpackage

// File: rtl/sd_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
// With clr and inc together the count restarts at 1 (clear, then count this sample).
module sd_sat_counter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = clr ? '0 : q_q;
      if (inc && !(&q_d)) begin
         q_d = q_d + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/sd_level_detect.sv
// Level event detector: qualifies a run of high magnitude samples into an event,
// releases it after a run of low samples, and reports the event's peak and length.
module sd_level_detect
   import sd_level_pkg::*;
#(
   parameter int unsigned WIDTH = SD_WIDTH_DEF,
   parameter int unsigned QUAL  = SD_QUAL_DEF,
   parameter int unsigned HOLD  = SD_HOLD_DEF,
   parameter int unsigned LEN_W = SD_LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] mag,
   input  logic [WIDTH-1:0] onThresh,
   input  logic [WIDTH-1:0] offThresh,
   output logic             active,
   output logic [WIDTH-1:0] peak,
   output logic [LEN_W-1:0] eventLen,
   output logic             resultValid
);

   localparam int unsigned CNT_MAX = (QUAL > HOLD) ? QUAL : HOLD;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] QUAL_C = CNT_W'(QUAL);
   localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

   sd_state_e        state_q, state_d;
   logic [WIDTH-1:0] run_peak_q, run_peak_d;
   logic             active_q, active_d;
   logic [WIDTH-1:0] peak_q, peak_d;
   logic [LEN_W-1:0] event_len_q, event_len_d;
   logic             result_valid_q, result_valid_d;

   logic             cnt_clr, cnt_inc;
   logic             len_clr, len_inc;
   logic [CNT_W-1:0] qh_cnt;
   logic [LEN_W-1:0] run_len;

   logic             above_on, below_off, finish;
   logic [WIDTH-1:0] peak_max;
   logic [LEN_W-1:0] len_next;

   // One counter serves both qualification (ARMING) and hold (HOLD); the two never overlap.
   sd_sat_counter #(.W(CNT_W)) u_qh_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .inc (cnt_inc),
      .q   (qh_cnt)
   );

   sd_sat_counter #(.W(LEN_W)) u_run_len (
      .clk (clk),
      .rst (rst),
      .clr (len_clr),
      .inc (len_inc),
      .q   (run_len)
   );

   always_comb begin
      state_d        = state_q;
      run_peak_d     = run_peak_q;
      peak_d         = peak_q;
      event_len_d    = event_len_q;
      result_valid_d = 1'b0;
      cnt_clr        = 1'b0;
      cnt_inc        = 1'b0;
      len_clr        = 1'b0;
      len_inc        = 1'b0;
      finish         = 1'b0;

      above_on  = (mag > onThresh);
      below_off = (mag < offThresh);
      peak_max  = (mag > run_peak_q) ? mag : run_peak_q;
      // Length including the current sample, for the finishing cycle.
      len_next  = (&run_len) ? run_len : run_len + LEN_W'(1);

      if (en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (above_on) begin
                  run_peak_d = mag;
                  len_clr    = 1'b1;
                  len_inc    = 1'b1;
                  cnt_clr    = 1'b1;
                  if (QUAL == 1) begin
                     state_d = ST_ACTIVE;
                  end else begin
                     state_d = ST_ARMING;
                     cnt_inc = 1'b1;
                  end
               end
            end
            ST_ARMING: begin
               run_peak_d = peak_max;
               len_inc    = 1'b1;
               if (above_on) begin
                  if ((qh_cnt + CNT_W'(1)) == QUAL_C) begin
                     state_d = ST_ACTIVE;
                     cnt_clr = 1'b1;
                  end else begin
                     cnt_inc = 1'b1;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cnt_clr = 1'b1;
               end
            end
            ST_ACTIVE: begin
               run_peak_d = peak_max;
               len_inc    = 1'b1;
               if (below_off) begin
                  if (HOLD == 1) begin
                     finish = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                     cnt_clr = 1'b1;
                     cnt_inc = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               run_peak_d = peak_max;
               len_inc    = 1'b1;
               if (!below_off) begin
                  state_d = ST_ACTIVE;
                  cnt_clr = 1'b1;
               end else if ((qh_cnt + CNT_W'(1)) == HOLD_C) begin
                  finish = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_clr = 1'b1;
            end
         endcase

         if (finish) begin
            state_d        = ST_IDLE;
            cnt_clr        = 1'b1;
            peak_d         = peak_max;
            event_len_d    = len_next;
            result_valid_d = 1'b1;
         end
      end

      active_d = (state_d == ST_ACTIVE) || (state_d == ST_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         run_peak_q     <= '0;
         active_q       <= 1'b0;
         peak_q         <= '0;
         event_len_q    <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         run_peak_q     <= run_peak_d;
         active_q       <= active_d;
         peak_q         <= peak_d;
         event_len_q    <= event_len_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign active      = active_q;
   assign peak        = peak_q;
   assign eventLen    = event_len_q;
   assign resultValid = result_valid_q;

endmodule

// File: doc/sd_level_detect.md
# sd_level_detect

Event detector placed directly downstream of the sigma-delta magnitude estimator. It takes the magnitude word, one per enabled cycle, and declares an "active" event once the level stays above an on-threshold for a qualifying number of samples. It releases the event after the level has stayed below an off-threshold for a hold period. At the end of each event it reports the peak magnitude and the event length as a one-cycle result pulse.

## Interface
- WIDTH, 16, magnitude / threshold / peak width (matches magnitude estimator output)
- QUAL, 4, consecutive samples above onThresh required to enter ACTIVE (≥1)
- HOLD, 8, consecutive samples below offThresh required to leave (≥1)
- LEN_W, 16, event length counter width
- clk  in  1  system clock
- rst  in  1  reset, active high & synchronous
- en  in  1  sample enable; one magnitude sample per cycle with en=1
- mag  in  WIDTH  unsigned magnitude sample
- onThresh  in  WIDTH  unsigned on-threshold, compared as mag > onThresh
- offThresh  in  WIDTH  unsigned off-threshold, compared as mag < offThresh
- active  out  1  event in progress (ACTIVE or HOLD)
- peak  out  WIDTH  max mag of the last completed event
- eventLen  out  LEN_W  sample count of the last completed event, saturating
- resultValid  out  1  one-cycle pulse when peak/eventLen update

## Operation
- FSM states are IDLE, ARMING, ACTIVE and HOLD. All transitions and updates occur only on cycles with en=1. With en=0, all state holds and resultValid=0.
- IDLE:
  - mag > onThresh → ARMING; qualCnt=1, runPeak=mag, runLen=1.
  - If QUAL==1, go straight to ACTIVE instead.
- ARMING:
  - mag > onThresh: qualCnt+1. On reaching QUAL → ACTIVE.
  - mag ≤ onThresh → IDLE; run registers are discarded and no result is produced.
- ACTIVE:
  - mag < offThresh → HOLD with holdCnt=1.
  - If HOLD==1, finish the event immediately instead.
- HOLD:
  - mag ≥ offThresh → ACTIVE; holdCnt cleared.
  - holdCnt reaching HOLD → finish.
- Finish: go to IDLE. Load peak←runPeak and eventLen←runLen, with the final sample included. Pulse resultValid.
- Run-register updates:
  - Every en sample from entry into ARMING through finish updates runPeak=max(runPeak,mag).
  - runLen increments by 1 per sample and saturates at 2^LEN_W−1.
- Thresholds are sampled live each en cycle. offThresh > onThresh is legal; the rules above apply literally.
- Counters qualCnt/holdCnt are sized $clog2(max(QUAL,HOLD))+1 and never wrap.

## Timing
- All outputs are registered.
- Reset values: active=0, peak=0, eventLen=0, resultValid=0, state IDLE, all counters 0.
- active rises on the clock edge that samples the QUAL-th consecutive qualifying en sample. Latency from the first qualifying sample is QUAL en-cycles.
- resultValid and the new peak/eventLen appear on the edge that samples the HOLD-th low sample. active falls on that same edge.
- Results hold until the next finish.
- rst mid-event returns to reset values on the next edge. No resultValid is produced for an aborted event.
- A new event can begin on the en sample directly after finish.

## Structure
- Shared package sd_level_pkg holds:
  - the state encoding localparams (IDLE=0, ARMING=1, ACTIVE=2, HOLD=3);
  - default parameter values.
- One sub-module, sd_sat_counter (parameter W; ports clr, inc, q; saturates at all-ones). It is instantiated for runLen and for the shared qual/hold counter.
- Comparators and the max logic stay inline.

## Test plan
All cases use QUAL=4, HOLD=8, onThresh=1000, offThresh=800.
- Reset: assert rst 3 cycles mid-stream → all outputs 0, active=0, state IDLE.
- Clean event: mag=1200 ×10, then 500 ×8 → active rises on the 4th 1200 sample. resultValid pulses on the 8th 500 sample with peak=1200 and eventLen=18.
- Failed arm: mag=1200 ×3, then 900 → never active, no resultValid. Next event's eventLen starts at 1.
- Hold re-entry: after active, send 500 ×5, then 850 ×1, then 500 ×8 → stays active throughout. Single result pulse with eventLen=4+5+1+8 plus prior ACTIVE samples.
- Enable gating: clean event with en toggling 1,0,1,0 → identical peak/eventLen to the en=1 case. resultValid is coincident with an en=1 cycle.
- Saturation and peak: LEN_W=4, 30-sample event with a single 5000 spike → eventLen=15, peak=5000.
